pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register for the processor datapath, generalising the fixed-field stage registers (e.g. decode→execute).
- Carries one packed DATA_W-bit bundle of control and data fields.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush that clears only control bits selected by a mask.
- Sits between any two pipeline stages; the hazard unit drives EN (stall) and CLR (flush).

---
 rtl/pipe_stage_reg.sv | 90 +++++++++
 tb/tb_pipe_stage_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with 2-entry skid buffer and masked flush.
// Define PIPE_STAGE_STATS_EN to add the saturating StallCnt output.
module pipe_stage_reg #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}},
    parameter bit                SKID     = 1'b1
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              EN,
    input  logic              CLR,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       StallCnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              rdy_q;
    logic              accept, drain;
    // rdy_q holds InReady low through reset and while the skid entry is occupied
    assign InReady   = rdy_q & EN & (SKID || state_q == EMPTY || OutReady);
    assign OutValid  = (state_q != EMPTY) & EN;
    assign OutData   = main_q;
    assign Occupancy = state_q;
    assign accept    = InValid & InReady & ~CLR;
    assign drain     = OutValid & OutReady & ~CLR;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (CLR) begin
            state_d = EMPTY;
            main_d  = main_q & ~CLR_MASK;
            skid_d  = skid_q & ~CLR_MASK;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    main_d  = InData;
                end
                ONE: if (accept && drain) begin
                    main_d = InData;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = InData;
                end else if (drain) begin
                    state_d = EMPTY;
                end
                TWO: if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= state_d != TWO;
        end
    end
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic        stall;
    assign stall    = (OutValid & ~OutReady) | (~EN & (state_q != EMPTY));
    assign stall_d  = (stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    assign StallCnt = stall_q;
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) stall_q <= '0;
        else         stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (skid and single-entry builds).
module tb_pipe_stage_reg;
    logic       CLK = 1'b0;
    logic       ResetN = 1'b1;
    logic       en = 1'b1, clr = 1'b0;
    logic       iv = 1'b0, ordy = 1'b0, irdy, ov;
    logic [7:0] id = '0, od;
    logic [1:0] occ;
    logic       iv0 = 1'b0, ordy0 = 1'b0, irdy0, ov0;
    logic [7:0] id0 = '0, od0;
    logic [1:0] occ0;
    logic [7:0] q[$];
    logic [7:0] q0[$];
    int         tests = 0, fails = 0;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] sc, sc0;
`endif

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(8), .CLR_MASK(8'hF0), .SKID(1'b1)) dut (
        .CLK(CLK), .ResetN(ResetN), .EN(en), .CLR(clr),
        .InValid(iv), .InReady(irdy), .InData(id),
        .OutValid(ov), .OutReady(ordy), .OutData(od), .Occupancy(occ)
`ifdef PIPE_STAGE_STATS_EN
        , .StallCnt(sc)
`endif
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(1'b0)) dut0 (
        .CLK(CLK), .ResetN(ResetN), .EN(en), .CLR(clr),
        .InValid(iv0), .InReady(irdy0), .InData(id0),
        .OutValid(ov0), .OutReady(ordy0), .OutData(od0), .Occupancy(occ0)
`ifdef PIPE_STAGE_STATS_EN
        , .StallCnt(sc0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // monitor: every completed downstream transfer is matched against the scoreboard queues
    always @(negedge CLK) begin
        if (ResetN && ov && ordy && !clr) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL drain_unexpected: got %0h expected none", od);
            end else chk("drain", 32'(od), 32'(q.pop_front()));
        end
        if (ResetN && ov0 && ordy0 && !clr) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL drain0_unexpected: got %0h expected none", od0);
            end else chk("drain0", 32'(od0), 32'(q0.pop_front()));
        end
    end

    initial begin
        #2 ResetN = 1'b0;
        #1;
        chk("rst_occ", 32'(occ), 0);
        chk("rst_ov", 32'(ov), 0);
        chk("rst_irdy", 32'(irdy), 0);
        chk("rst_od", 32'(od), 0);
        tick();
        ResetN = 1'b1;
        chk("rel_irdy", 32'(irdy), 0);
        tick();
        chk("post_rel_irdy", 32'(irdy), 1);
        // stream 1..8 at full throughput
        ordy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv = 1'b1; id = 8'(i); q.push_back(8'(i));
            tick();
            chk("stream_occ", 32'(occ), 1);
            chk("stream_ov", 32'(ov), 1);
            chk("stream_od", 32'(od), 32'(i));
        end
        iv = 1'b0;
        tick();
        chk("stream_empty", 32'(occ), 0);
        // back-pressure into the skid entry
        ordy = 1'b0; iv = 1'b1; id = 8'd5; q.push_back(8'd5);
        tick();
        chk("bp_occ1", 32'(occ), 1);
        id = 8'd6; q.push_back(8'd6);
        tick();
        iv = 1'b0;
        chk("bp_occ2", 32'(occ), 2);
        chk("bp_irdy", 32'(irdy), 0);
        tick();
        chk("bp_hold", 32'(occ), 2);
        // stall while full
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ov", 32'(ov), 0);
            chk("stall_irdy", 32'(irdy), 0);
            chk("stall_occ", 32'(occ), 2);
        end
        en = 1'b1; ordy = 1'b1;
        tick();
        chk("drain1_occ", 32'(occ), 1);
        chk("drain1_irdy", 32'(irdy), 1);
        chk("drain1_od", 32'(od), 6);
        tick();
        chk("drain2_occ", 32'(occ), 0);
        // masked flush discards the presented bundle
        ordy = 1'b0; iv = 1'b1; id = 8'hA5;
        tick();
        chk("pre_flush_od", 32'(od), 32'hA5);
        clr = 1'b1; id = 8'h33;
        tick();
        clr = 1'b0; iv = 1'b0;
        chk("flush_ov", 32'(ov), 0);
        chk("flush_occ", 32'(occ), 0);
        chk("flush_od", 32'(od), 32'h05);
        ordy = 1'b1;
        tick();
        chk("flush_stays_empty", 32'(occ), 0);
        // asynchronous reset while two entries are held
        ordy = 1'b0; iv = 1'b1; id = 8'h21;
        tick();
        id = 8'h22;
        tick();
        iv = 1'b0;
        chk("pre_rst_occ", 32'(occ), 2);
        #2 ResetN = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(ov), 0);
        chk("mid_rst_occ", 32'(occ), 0);
        chk("mid_rst_od", 32'(od), 0);
        #1 ResetN = 1'b1;
        tick();
        ordy = 1'b1; iv = 1'b1; id = 8'h11; q.push_back(8'h11);
        tick();
        iv = 1'b0;
        chk("after_rst_ov", 32'(ov), 1);
        chk("after_rst_od", 32'(od), 32'h11);
        tick();
        chk("after_rst_occ", 32'(occ), 0);
        // single-entry build: combinational InReady
        ordy0 = 1'b0; iv0 = 1'b1; id0 = 8'd9; q0.push_back(8'd9);
        tick();
        iv0 = 1'b0;
        #1;
        chk("s0_occ", 32'(occ0), 1);
        chk("s0_irdy_blocked", 32'(irdy0), 0);
        ordy0 = 1'b1;
        #1;
        chk("s0_irdy_comb", 32'(irdy0), 1);
        iv0 = 1'b1; id0 = 8'd7; q0.push_back(8'd7);
        tick();
        iv0 = 1'b0;
        chk("s0_swap_occ", 32'(occ0), 1);
        chk("s0_swap_od", 32'(od0), 7);
        tick();
        chk("s0_empty", 32'(occ0), 0);
        chk("sb_left", 32'(q.size()), 0);
        chk("sb0_left", 32'(q0.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
